icr_mem_responder: RTL

ICR_MEM_RESPONDER -- requirements
Module: icr_mem_responder

---
 rtl/icr_mem_responder.sv | 107 ++++++++++
 1 files changed

// File: rtl/icr_mem_responder.sv
// I-cache refill responder: fetches one 4-word line from a synchronous memory
// and presents it as a single 128-bit beat followed by a finish pulse.
module icr_mem_responder #(
  parameter int MWIDTH = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              icr_start_rq,
  input  logic [31:0]       ic_rin_addr,
  input  logic              rq_cancel,
  output logic [127:0]      rdat_m_data,
  output logic              ic_rdat_m_valid,
  output logic              ic_finish_mrd,
  output logic              rq_busy,
  output logic              rq_ovr,
  output logic              mem_ren,
  output logic [MWIDTH-1:0] mem_radr,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    WAIT = 3'd2,
    RESP = 3'd3,
    FIN  = 3'd4
  } state_t;

  state_t            state_q;
  logic [MWIDTH-3:0] line_q;
  logic [1:0]        beat_q;
  logic              ovr_q;
  logic              cap_vld_q;
  logic [1:0]        cap_lane_q;
  logic [31:0]       lane_q [4];

  // Offset within the line and address bits beyond the memory are don't-care.
  logic unused_addr;
  assign unused_addr = ^{ic_rin_addr[31:MWIDTH+2], ic_rin_addr[3:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      line_q     <= '0;
      beat_q     <= '0;
      ovr_q      <= 1'b0;
      cap_vld_q  <= 1'b0;
      cap_lane_q <= '0;
    end else begin
      // Memory data lags the read by one cycle; a cancel drops it.
      cap_vld_q  <= (state_q == RD) && !rq_cancel;
      cap_lane_q <= beat_q;

      if (icr_start_rq && state_q != IDLE) begin
        ovr_q <= 1'b1;
      end

      if (rq_cancel && state_q != IDLE) begin
        state_q <= IDLE;
        beat_q  <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (icr_start_rq && !rq_cancel) begin
              state_q <= RD;
              line_q  <= ic_rin_addr[MWIDTH+1:4];
              beat_q  <= '0;
            end
          end
          RD: begin
            beat_q <= beat_q + 2'd1;
            if (beat_q == 2'd3) begin
              state_q <= WAIT;
            end
          end
          WAIT:    state_q <= RESP;
          RESP:    state_q <= FIN;
          FIN:     state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  // Each 32-bit lane is only rewritten by its own beat, so the previous line
  // stays visible until the matching beat of the next request lands.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      always_ff @(posedge clk) begin
        if (rst) begin
          lane_q[gi] <= '0;
        end else if (cap_vld_q && !rq_cancel && cap_lane_q == 2'(gi)) begin
          lane_q[gi] <= mem_rdata;
        end
      end
      assign rdat_m_data[32*gi +: 32] = lane_q[gi];
    end
  endgenerate

  assign rq_busy         = (state_q != IDLE);
  assign mem_ren         = (state_q == RD);
  assign mem_radr        = {line_q, beat_q};
  assign ic_rdat_m_valid = (state_q == RESP);
  assign ic_finish_mrd   = (state_q == FIN);
  assign rq_ovr          = ovr_q;

endmodule
